// File: rtl/pinball_pkg.sv
// Shared types and constants for the pinball scoring logic.
package pinball_pkg;

    localparam int unsigned BCD_DIGITS    = 3;
    localparam int unsigned SCORE_W       = 4 * BCD_DIGITS;
    localparam int unsigned LIVES_W       = 3;
    localparam int unsigned CD_W          = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX_BCD = 12'h999;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        COOLDOWN  = 2'd2,
        GAME_OVER = 2'd3
    } score_state_t;

endpackage

// File: rtl/bcd_add_sat.sv
// Combinational BCD adder: multi-digit BCD value plus one BCD digit,
// saturating at SCORE_MAX_BCD when the top digit carries out.
module bcd_add_sat
    import pinball_pkg::*;
(
    input  logic [SCORE_W-1:0] i_a,
    input  logic [3:0]         i_b,
    output logic [SCORE_W-1:0] o_sum_c
);

    logic [4:0]         w_dsum;
    logic               w_carry;
    logic [SCORE_W-1:0] w_sum;

    // Ripple the carry digit by digit; any carry out of the top digit saturates.
    always_comb begin
        w_dsum  = '0;
        w_carry = 1'b0;
        w_sum   = '0;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            w_dsum = 5'(i_a[4*d +: 4]) + 5'(w_carry) + ((d == 0) ? 5'(i_b) : 5'd0);
            if (w_dsum > 5'd9) begin
                w_sum[4*d +: 4] = 4'(w_dsum - 5'd10);
                w_carry         = 1'b1;
            end else begin
                w_sum[4*d +: 4] = w_dsum[3:0];
                w_carry         = 1'b0;
            end
        end
        o_sum_c = w_carry ? SCORE_MAX_BCD : w_sum;
    end

endmodule

// File: rtl/score_keeper.sv
// Turns per-pixel collision flags into per-frame game events and keeps
// score, high score, lives and the game-flow state.
module score_keeper
    import pinball_pkg::*;
#(
    parameter int unsigned POINTS_PER_HIT  = 1,
    parameter int unsigned LIVES_INIT      = 3,
    parameter int unsigned COOLDOWN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               collisionSmileyObstacle,
    input  logic               collisionSmileyBorderBottom,
    input  logic               newGame,
    output logic [SCORE_W-1:0] score_bcd,
    output logic [SCORE_W-1:0] high_bcd,
    output logic [LIVES_W-1:0] lives,
    output logic               pause,
    output logic               reset_level,
    output logic               game_over,
    output logic               hit_pulse
);

    score_state_t       r_state;
    logic               r_obs_seen;
    logic               r_bot_seen;
    logic               r_obs_prev;
    logic               r_ng_prev;
    logic [CD_W-1:0]    r_cd;

    score_state_t       w_state_nxt;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [SCORE_W-1:0] w_high_nxt;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic [CD_W-1:0]    w_cd_nxt;
    logic               w_hit_nxt;
    logic               w_rl_nxt;
    logic [SCORE_W-1:0] w_score_inc;
    logic               w_obs_ev;
    logic               w_bot_ev;
    logic               w_ng_edge;

    // Obstacle scores only on the first frame of a contact.
    assign w_obs_ev  = startOfFrame & r_obs_seen & ~r_obs_prev;
    assign w_bot_ev  = startOfFrame & r_bot_seen;
    assign w_ng_edge = newGame & ~r_ng_prev;

    bcd_add_sat u_add (
        .i_a     (score_bcd),
        .i_b     (4'(POINTS_PER_HIT)),
        .o_sum_c (w_score_inc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = score_bcd;
        w_high_nxt  = high_bcd;
        w_lives_nxt = lives;
        w_cd_nxt    = r_cd;
        w_hit_nxt   = 1'b0;
        w_rl_nxt    = 1'b0;
        case (r_state)
            IDLE, GAME_OVER: begin
                if (w_ng_edge) begin
                    w_state_nxt = PLAY;
                    w_score_nxt = '0;
                    w_lives_nxt = LIVES_W'(LIVES_INIT);
                    w_cd_nxt    = '0;
                    w_rl_nxt    = 1'b1;
                end
            end
            PLAY: begin
                // Score first, so a simultaneous final life loss records the new score.
                if (w_obs_ev) begin
                    w_score_nxt = w_score_inc;
                    w_hit_nxt   = 1'b1;
                end
                if (w_bot_ev) begin
                    if (lives > LIVES_W'(1)) begin
                        w_lives_nxt = lives - LIVES_W'(1);
                        w_cd_nxt    = CD_W'(COOLDOWN_FRAMES);
                        w_rl_nxt    = 1'b1;
                        w_state_nxt = COOLDOWN;
                    end else begin
                        w_lives_nxt = '0;
                        w_state_nxt = GAME_OVER;
                        w_high_nxt  = (w_score_nxt > high_bcd) ? w_score_nxt : high_bcd;
                    end
                end
            end
            COOLDOWN: begin
                if (startOfFrame) begin
                    w_cd_nxt = r_cd - CD_W'(1);
                    if (r_cd <= CD_W'(1)) begin
                        w_cd_nxt    = '0;
                        w_state_nxt = PLAY;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_obs_seen  <= 1'b0;
            r_bot_seen  <= 1'b0;
            r_obs_prev  <= 1'b0;
            r_ng_prev   <= 1'b0;
            r_cd        <= '0;
            score_bcd   <= '0;
            high_bcd    <= '0;
            lives       <= LIVES_W'(LIVES_INIT);
            pause       <= 1'b1;
            game_over   <= 1'b0;
            reset_level <= 1'b0;
            hit_pulse   <= 1'b0;
        end else begin
            // A collision coincident with the frame strobe belongs to the new frame.
            if (startOfFrame) begin
                r_obs_seen <= collisionSmileyObstacle;
                r_bot_seen <= collisionSmileyBorderBottom;
                r_obs_prev <= r_obs_seen;
            end else begin
                r_obs_seen <= r_obs_seen | collisionSmileyObstacle;
                r_bot_seen <= r_bot_seen | collisionSmileyBorderBottom;
            end
            r_ng_prev   <= newGame;
            r_state     <= w_state_nxt;
            r_cd        <= w_cd_nxt;
            score_bcd   <= w_score_nxt;
            high_bcd    <= w_high_nxt;
            lives       <= w_lives_nxt;
            pause       <= (w_state_nxt != PLAY);
            game_over   <= (w_state_nxt == GAME_OVER);
            reset_level <= w_rl_nxt;
            hit_pulse   <= w_hit_nxt;
        end
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Consumes the per-pixel collision flags from CollisionDetector and the frame strobe from VGA_Controller, plus a new-game request from keyboard_block.
- Converts collisions into per-frame game events: points, lives lost, game over.
- Holds a 3-digit BCD score, a BCD high score and a lives counter.
- Downstream, the hex_ss instances display the score, and smiley_block/flipper_block take pause/reset_level from it.

Parameters:
- POINTS_PER_HIT, 1, BCD points added per obstacle hit (1..9).
- LIVES_INIT, 3, lives at game start (1..7).
- COOLDOWN_FRAMES, 60, frames during which bottom collisions are ignored after a life is lost (1..255).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at start of each frame
- collisionSmileyObstacle  in  1  level, high on any pixel where ball overlaps obstacle
- collisionSmileyBorderBottom  in  1  level, high on any pixel where ball overlaps bottom border
- newGame  in  1  level (key5IsPressed); rising edge requests a new game
- score_bcd  out  12  current score, 3 BCD digits, [3:0] = ones
- high_bcd  out  12  best score since reset, BCD
- lives  out  3  remaining lives
- pause  out  1  high while not in PLAY
- reset_level  out  1  one-cycle pulse; re-launches ball and flipper
- game_over  out  1  high in GAME_OVER
- hit_pulse  out  1  one-cycle pulse when points are added

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - score_bcd=0, high_bcd=0, lives=LIVES_INIT, state=IDLE.
  - pause=1, game_over=0, reset_level=0, hit_pulse=0, all latches and counter cleared.
- Frame latching:
  - obs_seen and bot_seen are sticky-set by their collision inputs during a frame.
  - On startOfFrame: frame flags are sampled and obs_seen/bot_seen are cleared in the same cycle.
  - A collision coincident with startOfFrame counts toward the new frame.
- Obstacle event: fires at startOfFrame when obs_seen=1 and obs_prev=0. obs_prev holds the previous frame's obs_seen, so one point per contact, not per frame.
- Bottom event: fires at startOfFrame when bot_seen=1.
- States (pinball_pkg::score_state_t):
  - IDLE: pause=1. Rising edge of newGame -> PLAY; score:=0, lives:=LIVES_INIT, reset_level pulses the cycle after the transition.
  - PLAY: pause=0.
    - Obstacle event: score := score + POINTS_PER_HIT in BCD, saturating at 999; hit_pulse=1 on the cycle after startOfFrame.
    - Bottom event with lives>1: lives-1, cooldown:=COOLDOWN_FRAMES, reset_level pulse -> COOLDOWN.
    - Bottom event with lives==1: lives:=0 -> GAME_OVER.
    - Both events in one frame: score updates first, then the life is lost.
  - COOLDOWN: pause=1. Counter decrements on each startOfFrame; events are ignored. Count 0 -> PLAY.
  - GAME_OVER: pause=1, game_over=1.
    - On entry cycle: high_bcd := max(high_bcd, score_bcd), compared as a 12-bit unsigned value (valid for BCD).
    - Score is held.
    - Rising edge of newGame -> PLAY with the same init as from IDLE.
- newGame edge detect:
  - Registered prev sample; an edge is newGame & ~prev.
  - An edge in PLAY or COOLDOWN is ignored.
- Latency:
  - score, lives and state update 1 cycle after the startOfFrame that sampled the event.
  - reset_level and hit_pulse assert in that same cycle, width exactly 1.
- BCD rules:
  - Digits are always 0..9.
  - Ones carries into tens, tens into hundreds.
  - Any carry out of hundreds forces 999.

Decomposition:
- pinball_pkg:
  - score_state_t enum {IDLE, PLAY, COOLDOWN, GAME_OVER}.
  - BCD_DIGITS=3 and SCORE_MAX_BCD=12'h999.
- One sub-module, bcd_add_sat:
  - Combinational, inputs 12-bit BCD a and 4-bit BCD b, output 12-bit saturated sum.
  - Instantiated once.

Test Plan:
- Reset, then newGame rising edge -> state PLAY, pause=0, score_bcd=12'h000, lives=3, single reset_level pulse.
- Obstacle collision held for 5 consecutive frames, then released for 1 frame, then 1 frame again -> score 000->001->002 (two points), hit_pulse exactly twice.
- Score preloaded to 12'h099 then hit -> 12'h100; preloaded 12'h999 then hit -> stays 12'h999.
- Bottom collision in PLAY with lives=3 -> lives=2, reset_level pulse, pause=1 for COOLDOWN_FRAMES frames; bottom collisions during cooldown don't change lives; then PLAY.
- Three lives lost with score 12'h042, high 12'h017 -> GAME_OVER, game_over=1, high_bcd=12'h042; newGame held high across entry causes no restart until released and re-pressed.
- Obstacle and bottom collision in same frame with lives=1 -> score+1 and GAME_OVER together; synchronous reset asserted mid-COOLDOWN -> all outputs at reset values next cycle, high_bcd=0.
